seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the peripheral bus side of the CPU.
- Drives the 2-bit digit select, per-digit anode enables (active-low, one-hot-zero), hex segment pattern and decimal point.
- Inserts an anti-ghosting blank guard between digits.
- Accepts new display values via a load handshake and applies them only at frame boundaries, so a frame never shows mixed old/new digits.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- DIGIT_HZ, 1000, per-digit refresh rate; TICKS = CLK_HZ/DIGIT_HZ cycles per digit slot. Must be integer, ≥ BLANK_CYC+2.
- BLANK_CYC, 16, guard cycles at the end of each slot with all anodes off; range 1..TICKS-2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-high.
- en_i  in  1  display enable.
- value_i  in  16  four hex nibbles; digit k = value_i[4k+3:4k].
- dp_i  in  4  decimal point per digit, 1 = lit; captured with value_i.
- lz_en_i  in  1  leading-zero suppression enable; sampled at frame start.
- load_i  in  1  one-cycle request to capture value_i/dp_i.
- upd_ack_o  out  1  one-cycle pulse when a captured value becomes the displayed value.
- sel_o  out  2  current digit index.
- an_o  out  4  anode enables, active-low.
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_o  out  1  decimal point, active-low.
- frame_o  out  1  one-cycle pulse at the start of each digit-0 SHOW.

Behaviour:
- Outputs are registered. an_o, seg_o and dp_o change on the same edge.
- Reset values: sel_o=0, an_o=4'b1111, seg_o=7'h7F, dp_o=1, upd_ack_o=0, frame_o=0.
- Reset also clears the displayed register to 0, the displayed dp to 0, the pending flag and all counters. The state after reset is IDLE.
- Reset mid-operation aborts immediately and discards any pending load.
- FSM states:
  - IDLE: an_o=1111, seg_o=7F, dp_o=1, tick counter held at 0. If en_i=1, go to SHOW with sel=0 and perform a frame start.
  - SHOW: an_o = selected digit low, others high; seg_o/dp_o from the displayed register. Lasts TICKS-BLANK_CYC cycles, then go to GUARD.
  - GUARD: an_o=1111, seg_o=7F, dp_o=1. Lasts BLANK_CYC cycles. Then sel wraps 3→0. If the new sel=0, perform a frame start. Go to SHOW.
- Anode mapping: sel 0→1110, 1→1101, 2→1011, 3→0111.
- Frame start actions:
  - Pulse frame_o.
  - If pending=1: copy pending value/dp to the displayed registers, clear pending, pulse upd_ack_o (same cycle as frame_o).
  - Latch lz_en_i.
- Load handshake:
  - load_i=1 copies value_i/dp_i into the pending register and sets pending. This is accepted in any state, including IDLE.
  - Load while pending=1: overwrite (latest wins). Exactly one upd_ack_o is issued when the latest value is applied.
  - Load in the same cycle as a frame start: the old pending value is applied. The new value becomes pending and applies at the next frame start.
- en_i deasserted in SHOW or GUARD: on the next edge go to IDLE, outputs blank, sel_o=0, tick counter=0. Pending is retained.
- Leading-zero suppression (latched lz=1):
  - Digit k (k=3..1) is blanked (seg_o=7F) when nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - dp_o is still driven from dp for blanked digits.
- Hex decode: 0-F standard patterns, e.g. 0→7'h40, 1→7'h79, 8→7'h00, F→7'h0E.
- Tick counter width is $clog2(TICKS). It restarts at 0 on every state change.

Decomposition:
- Package seg7_pkg:
  - state enum {IDLE, SHOW, GUARD}
  - SEG_OFF=7'h7F, AN_OFF=4'hF
  - 16-entry hex segment constant array
- Sub-module seg7_hex_decode: combinational, 4-bit nibble + blank → 7-bit active-low pattern. It is instantiated once, after the nibble mux.

Test Plan:
Bench uses CLK_HZ=1000, DIGIT_HZ=100 (TICKS=10), BLANK_CYC=2.
- Reset, then en_i=1 with no load → sel cycles 0,1,2,3. Each slot is 8 cycles SHOW (an_o 1110/1101/1011/0111, seg_o=40) then 2 cycles an_o=1111. frame_o pulses every 40 cycles.
- load_i with value_i=16'h12AF, dp_i=4'b0100 mid-frame → no change until next frame_o. upd_ack_o coincides with frame_o. Digits show F(0E), A(08), 2(24), 1(79). dp_o=0 only at sel=2.
- Two loads (16'h1111, then 16'h2222) within one frame → a single upd_ack_o; display shows 2222.
- lz_en_i=1, value 16'h0030 → digits 3 and 2 blank (seg_o=7F, anode still low), digit 1 shows 3 (30), digit 0 shows 0 (40). Value 16'h0000 → only digit 0 shows 40.
- en_i dropped during sel=2 SHOW → next cycle an_o=1111, sel_o=0. Re-enable → frame_o pulses on the first SHOW of digit 0.
- rst_i asserted mid-GUARD with pending=1 → next cycle all outputs at reset values. After re-enable, the display shows 0000 and no upd_ack_o occurs.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Pure definitions: no latency, no flow control.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 never is.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] k);
    logic r;
    r = 1'b0;
    case (k)
      2'd3:    r = (v[15:12] == 4'h0);
      2'd2:    r = (v[15:8] == 8'h00);
      2'd1:    r = (v[15:4] == 12'h000);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low seven-segment pattern, with forced blank.
// Latency: combinational. Backpressure: none.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Blank overrides the table lookup.
  always_comb begin
    o_seg = i_blank ? SEG_OFF : HEX_SEG[i_nib];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan controller with guard blanking and frame-aligned updates.
// Latency: outputs registered; they reflect the state entered on the same edge.
// Backpressure: none; load_i always accepted, latest pending value wins.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int DIGIT_HZ  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        lz_en_i,
  input  logic        load_i,
  output logic        upd_ack_o,
  output logic [1:0]  sel_o,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int TICKS = CLK_HZ / DIGIT_HZ;
  localparam int TW    = $clog2(TICKS);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(TICKS - BLANK_CYC - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(BLANK_CYC - 1);

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic [1:0]    r_sel, w_sel_nxt;
  logic          w_frame_start;

  logic [15:0]   r_disp, r_pend, w_disp_nxt;
  logic [3:0]    r_disp_dp, r_pend_dp, w_ddp_nxt;
  logic          r_pend_vld, r_lz, w_lz_nxt, w_apply;

  logic          w_show, w_blank, w_dp_nxt;
  logic [3:0]    w_nib, w_an_nxt;
  logic [6:0]    w_seg_nxt;

  logic          r_ack, r_frame, r_dp;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  // State, slot tick and digit select registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_sel   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Next state: SHOW for TICKS-BLANK_CYC cycles, GUARD for BLANK_CYC, enable drop wins.
  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick + 1'b1;
    w_sel_nxt     = r_sel;
    w_frame_start = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick_nxt = '0;
        w_sel_nxt  = 2'd0;
        if (en_i) begin
          w_state_nxt   = SHOW;
          w_frame_start = 1'b1;
        end
      end
      SHOW: begin
        if (!en_i) begin
          w_state_nxt = IDLE;
          w_tick_nxt  = '0;
          w_sel_nxt   = 2'd0;
        end else if (r_tick == SHOW_LAST) begin
          w_state_nxt = GUARD;
          w_tick_nxt  = '0;
        end
      end
      GUARD: begin
        if (!en_i) begin
          w_state_nxt = IDLE;
          w_tick_nxt  = '0;
          w_sel_nxt   = 2'd0;
        end else if (r_tick == GUARD_LAST) begin
          w_state_nxt   = SHOW;
          w_tick_nxt    = '0;
          w_sel_nxt     = r_sel + 2'd1;
          w_frame_start = (r_sel == 2'd3);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tick_nxt  = '0;
        w_sel_nxt   = 2'd0;
      end
    endcase
  end

  // Frame-start view of the display registers, so the first digit-0 cycle already shows new data.
  always_comb begin
    w_apply    = w_frame_start & r_pend_vld;
    w_disp_nxt = w_apply ? r_pend : r_disp;
    w_ddp_nxt  = w_apply ? r_pend_dp : r_disp_dp;
    w_lz_nxt   = w_frame_start ? lz_en_i : r_lz;
  end

  // Output decode for the state being entered.
  always_comb begin
    w_show   = (w_state_nxt == SHOW);
    w_nib    = w_disp_nxt[{w_sel_nxt, 2'b00} +: 4];
    w_blank  = !w_show || (w_lz_nxt && lz_blank(w_disp_nxt, w_sel_nxt));
    w_an_nxt = w_show ? ~(4'b0001 << w_sel_nxt) : AN_OFF;
    w_dp_nxt = w_show ? ~w_ddp_nxt[w_sel_nxt] : 1'b1;
  end

  seg7_hex_decode u_dec (
    .i_nib   (w_nib),
    .i_blank (w_blank),
    .o_seg   (w_seg_nxt)
  );

  // Displayed and pending value registers; a load at frame start queues behind the applied value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_disp     <= 16'h0000;
      r_disp_dp  <= 4'h0;
      r_pend     <= 16'h0000;
      r_pend_dp  <= 4'h0;
      r_pend_vld <= 1'b0;
      r_lz       <= 1'b0;
    end else begin
      r_disp    <= w_disp_nxt;
      r_disp_dp <= w_ddp_nxt;
      r_lz      <= w_lz_nxt;
      if (load_i) begin
        r_pend     <= value_i;
        r_pend_dp  <= dp_i;
        r_pend_vld <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // Registered display outputs and one-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_an    <= AN_OFF;
      r_seg   <= SEG_OFF;
      r_dp    <= 1'b1;
      r_ack   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_dp    <= w_dp_nxt;
      r_ack   <= w_apply;
      r_frame <= w_frame_start;
    end
  end

  assign sel_o     = r_sel;
  assign an_o      = r_an;
  assign seg_o     = r_seg;
  assign dp_o      = r_dp;
  assign upd_ack_o = r_ack;
  assign frame_o   = r_frame;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: 10-cycle slots (8 lit + 2 guard), 40-cycle frames.
// Reference model tracks position within the frame and the pending/displayed values.
// Every cycle all outputs are compared 1 ns after the rising edge.
module tb_seg7_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, lz, load;
  logic [15:0] val;
  logic [3:0]  dpi;
  logic        ack, frame, dpo;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic [6:0]  seg;

  seg7_scan_ctrl #(.CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYC(2)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .value_i(val), .dp_i(dpi),
    .lz_en_i(lz), .load_i(load), .upd_ack_o(ack), .sel_o(sel), .an_o(an),
    .seg_o(seg), .dp_o(dpo), .frame_o(frame)
  );

  int checks = 0;
  int failures = 0;
  int ack_seen = 0;

  // Reference model state.
  logic        m_run;
  int          m_pos;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  logic        m_pvld, m_lz;
  logic        e_ack, e_frame, e_dp;
  logic [1:0]  e_sel;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    logic fs;
    int   dig;
    e_ack   = 1'b0;
    e_frame = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_disp = '0; m_ddp = '0;
      m_pend = '0; m_pdp = '0; m_pvld = 1'b0; m_lz = 1'b0;
    end else begin
      fs = 1'b0;
      if (!en) begin
        m_run = 1'b0; m_pos = 0;
      end else if (!m_run) begin
        m_run = 1'b1; m_pos = 0; fs = 1'b1;
      end else begin
        m_pos = (m_pos + 1) % 40;
        fs = (m_pos == 0);
      end
      if (fs && m_pvld) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pvld = 1'b0; e_ack = 1'b1;
      end
      if (fs) m_lz = lz;
      if (load) begin
        m_pend = val; m_pdp = dpi; m_pvld = 1'b1;
      end
      e_frame = fs;
    end
    dig = m_run ? m_pos / 10 : 0;
    e_sel = 2'(dig);
    if (m_run && (m_pos % 10) < 8) begin
      e_an = ~(4'b0001 << dig);
      e_dp = ~m_ddp[dig];
      if (m_lz && dig > 0 && (m_disp >> (4 * dig)) == 16'h0000) e_seg = 7'h7F;
      else e_seg = hex7(m_disp[4*dig +: 4]);
    end else begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    if (ack === 1'b1) ack_seen++;
    chk("sel_o", 16'(sel), 16'(e_sel));
    chk("an_o", 16'(an), 16'(e_an));
    chk("seg_o", 16'(seg), 16'(e_seg));
    chk("dp_o", 16'(dpo), 16'(e_dp));
    chk("frame_o", 16'(frame), 16'(e_frame));
    chk("upd_ack_o", 16'(ack), 16'(e_ack));
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    val = v; dpi = d; load = 1'b1;
    step();
  endtask

  // Advance until the model frame position lies in [lo,hi]; bounded.
  task automatic wait_pos(input int lo, input int hi);
    int n;
    n = 0;
    while (!(m_run && m_pos >= lo && m_pos <= hi) && n < 100) begin
      step(); n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $error("FAIL wait_pos observed=timeout expected=pos%0d..%0d", lo, hi);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; lz = 1'b0; load = 1'b0; val = '0; dpi = '0;
    m_run = 1'b0; m_pos = 0;
    run(2);
    rst = 1'b0;
    run(2);
    // Free-running with the reset value 0000.
    en = 1'b1;
    run(45);
    // Mid-frame load; applies only at the next frame start.
    do_load(16'h12AF, 4'b0100);
    run(85);
    // Two loads within one frame produce one acknowledge.
    wait_pos(3, 5);
    ack_seen = 0;
    do_load(16'h1111, 4'b0000);
    run(5);
    do_load(16'h2222, 4'b1000);
    run(60);
    chk("ack_count", 16'(ack_seen), 16'd1);
    // Leading-zero suppression.
    lz = 1'b1;
    do_load(16'h0030, 4'b0001);
    run(85);
    do_load(16'h0000, 4'b0110);
    run(85);
    // Drop enable during digit-2 SHOW, then re-enable.
    wait_pos(22, 25);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(50);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        val = 16'($urandom); dpi = 4'($urandom); load = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) lz = ~lz;
      step();
    end
    // Reset in GUARD with a pending load: pending must be discarded.
    en = 1'b1; lz = 1'b0;
    wait_pos(5, 7);
    wait_pos(8, 8);
    do_load(16'hBEEF, 4'b1111);
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0;
    run(2);
    en = 1'b1;
    ack_seen = 0;
    run(90);
    chk("ack_after_reset", 16'(ack_seen), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
